// File: rtl/prim_fifo_wr_arb.sv
// prim_fifo_wr_arb
// ----------------------------------------------------------------------------
// Round-robin write arbiter that shares one prim_fifo_sync write port among
// NumReq requesters. Each accepted word is tagged with its source ID. With
// PRIM_FIFO_ARB_QUOTA_EN defined, per-source occupancy counters are kept from
// accepts and pops, and a source holding Quota entries in the FIFO is masked
// from arbitration. Without the macro the counters are absent, every valid
// request is eligible and occ_o is tied to zero.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   clr_i             synchronous flush, pulsed together with the FIFO clear
//   req_valid_i       per-requester valid
//   req_ready_o       per-requester ready (one-hot or zero)
//   req_data_i        per-requester data, requester i at [i*Width +: Width]
//   fifo_wvalid_o     to FIFO wvalid_i
//   fifo_wready_i     from FIFO wready_o
//   fifo_wdata_o      granted data, zero when fifo_wvalid_o is low
//   fifo_wid_o        granted source ID, zero when fifo_wvalid_o is low
//   fifo_pop_i        FIFO rvalid_o & rready_i
//   fifo_pop_id_i     ID field of the entry being popped
//   occ_o             per-source resident count, source i at [i*CntW +: CntW]
//   dbg_state_o       FSM state (0 = IDLE, 1 = HOLD)
//   dbg_ptr_o         round-robin pointer
//
// Handshake: a requester raises req_valid_i with stable data and keeps both
// until it sees req_ready_o high at a clock edge; that edge is the transfer.
// The FIFO side follows the same rule with fifo_wvalid_o/fifo_wready_i.
// ----------------------------------------------------------------------------
module prim_fifo_wr_arb #(
    parameter int NumReq    = 4,
    parameter int Width     = 16,
    parameter int FifoDepth = 4,
    parameter int Quota     = 2,
    localparam int IdW      = (NumReq > 1) ? $clog2(NumReq) : 1,
    localparam int CntW     = $clog2(FifoDepth + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic [NumReq-1:0]        req_valid_i,
    output logic [NumReq-1:0]        req_ready_o,
    input  logic [NumReq*Width-1:0]  req_data_i,
    output logic                     fifo_wvalid_o,
    input  logic                     fifo_wready_i,
    output logic [Width-1:0]         fifo_wdata_o,
    output logic [IdW-1:0]           fifo_wid_o,
    input  logic                     fifo_pop_i,
    input  logic [IdW-1:0]           fifo_pop_id_i,
    output logic [NumReq*CntW-1:0]   occ_o,
    output logic [0:0]               dbg_state_o,
    output logic [IdW-1:0]           dbg_ptr_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [IdW-1:0]    ptr_q, ptr_d;
    logic [IdW-1:0]    hold_id_q, hold_id_d;

    logic [NumReq-1:0] eligible;
    logic              idle_found;
    logic [IdW-1:0]    idle_win;
    logic [IdW-1:0]    grant_id;
    logic [IdW-1:0]    next_ptr;
    logic              wvalid_int;
    logic              accept;
    logic [Width-1:0]  req_data_arr [NumReq];

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            req_data_arr[i] = req_data_i[i*Width +: Width];
        end
    end

    // First eligible requester at or after the pointer, searching cyclically.
    always_comb begin
        int cand;
        cand       = 0;
        idle_found = 1'b0;
        idle_win   = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            if (!idle_found && eligible[IdW'(cand)]) begin
                idle_found = 1'b1;
                idle_win   = IdW'(cand);
            end
        end
    end

    // HOLD keeps the grant on the latched requester no matter what the other
    // requesters or the quota do, so the presented word never changes under
    // a stalled FIFO.
    assign grant_id   = (state_q == ST_HOLD) ? hold_id_q : idle_win;
    assign wvalid_int = !(rst_i || clr_i) &&
                        ((state_q == ST_HOLD) || idle_found);
    assign accept     = wvalid_int && fifo_wready_i;
    assign next_ptr   = (grant_id == IdW'(NumReq - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            req_ready_o[i] = accept && (grant_id == IdW'(i));
        end
    end

    assign fifo_wvalid_o = wvalid_int;
    assign fifo_wdata_o  = wvalid_int ? req_data_arr[grant_id] : '0;
    assign fifo_wid_o    = wvalid_int ? grant_id : '0;
    assign dbg_state_o   = state_q;
    assign dbg_ptr_o     = ptr_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_id_d = hold_id_q;
        if (state_q == ST_IDLE) begin
            if (idle_found) begin
                if (fifo_wready_i) begin
                    ptr_d = next_ptr;
                end else begin
                    state_d   = ST_HOLD;
                    hold_id_d = idle_win;
                end
            end
        end else if (fifo_wready_i) begin
            ptr_d   = next_ptr;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            hold_id_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_id_q <= hold_id_d;
        end
    end

`ifdef PRIM_FIFO_ARB_QUOTA_EN
    logic [CntW-1:0]   occ_q [NumReq];
    logic [CntW-1:0]   occ_d [NumReq];
    logic [NumReq-1:0] inc_vec;
    logic [NumReq-1:0] dec_vec;

    // Eligibility uses the registered count, so a pop frees a slot for its
    // source only from the following cycle.
    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            eligible[i] = req_valid_i[i] && (occ_q[i] < CntW'(Quota));
            inc_vec[i]  = accept && (grant_id == IdW'(i));
            dec_vec[i]  = fifo_pop_i && (fifo_pop_id_i == IdW'(i));
        end
    end

    // Same-source push and pop cancel; otherwise each applies, saturating.
    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            occ_d[i] = occ_q[i];
            if (inc_vec[i] && !dec_vec[i] && (occ_q[i] != CntW'(FifoDepth))) begin
                occ_d[i] = occ_q[i] + 1'b1;
            end else if (dec_vec[i] && !inc_vec[i] && (occ_q[i] != '0)) begin
                occ_d[i] = occ_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NumReq; i++) begin
            if (rst_i || clr_i) begin
                occ_q[i] <= '0;
            end else begin
                occ_q[i] <= occ_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            occ_o[i*CntW +: CntW] = occ_q[i];
        end
    end

`ifndef SYNTHESIS
    pop_not_at_zero_a: assert property (@(posedge clk_i) disable iff (rst_i || clr_i)
        fifo_pop_i |-> (occ_q[fifo_pop_id_i] != '0));
`endif
`else
    assign eligible = req_valid_i;
    assign occ_o    = '0;

    // Read-side observation only matters when occupancy is tracked.
    logic unused_pop;
    assign unused_pop = ^{fifo_pop_i, fifo_pop_id_i};
`endif

`ifndef SYNTHESIS
    for (genvar g = 0; g < NumReq; g++) begin : g_req_stable
        req_stable_a: assert property (@(posedge clk_i) disable iff (rst_i || clr_i)
            (req_valid_i[g] && !req_ready_o[g]) |=>
            (req_valid_i[g] && $stable(req_data_i[g*Width +: Width])));
    end
`endif

endmodule

// File: tb/tb_prim_fifo_wr_arb.sv
// tb_prim_fifo_wr_arb
// ----------------------------------------------------------------------------
// Bench for prim_fifo_wr_arb (NumReq=4, Width=16, FifoDepth=4, Quota=2).
// Directed scenarios for reset, fairness, hold and flush, plus a randomized
// run checked against a reference model that keeps the FIFO contents as a
// queue of source IDs and derives grants from a favoured-index integer.
// Quota scenarios are compiled in when PRIM_FIFO_ARB_QUOTA_EN is defined.
// Inputs change 1 time unit after the rising edge; outputs are checked 4
// time units after the rising edge.
// ----------------------------------------------------------------------------
module tb_prim_fifo_wr_arb;

    localparam int NUM_REQ    = 4;
    localparam int WIDTH      = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int QUOTA      = 2;
    localparam int IDW        = 2;
    localparam int CW         = 3;
    localparam int SBW        = IDW + WIDTH;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     clr = 1'b0;
    logic [NUM_REQ-1:0]       valid = '0;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [WIDTH-1:0]         dat [NUM_REQ];
    logic                     fifo_wvalid_o;
    logic                     wready = 1'b0;
    logic [WIDTH-1:0]         fifo_wdata_o;
    logic [IDW-1:0]           fifo_wid_o;
    logic                     pop = 1'b0;
    logic [IDW-1:0]           pop_id = '0;
    logic [NUM_REQ*CW-1:0]    occ_o;
    logic [0:0]               dbg_state_o;
    logic [IDW-1:0]           dbg_ptr_o;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_ptr  = 0;     // index favoured by the next arbitration
    int m_hold = -1;    // locked requester, -1 when none
    int ids_q[$];       // source IDs resident in the FIFO, oldest first
    logic [SBW-1:0] exp_q[$];

    prim_fifo_wr_arb #(
        .NumReq(NUM_REQ), .Width(WIDTH), .FifoDepth(FIFO_DEPTH), .Quota(QUOTA)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clr_i(clr),
        .req_valid_i(valid), .req_ready_o(req_ready_o), .req_data_i(req_data),
        .fifo_wvalid_o(fifo_wvalid_o), .fifo_wready_i(wready),
        .fifo_wdata_o(fifo_wdata_o), .fifo_wid_o(fifo_wid_o),
        .fifo_pop_i(pop), .fifo_pop_id_i(pop_id), .occ_o(occ_o),
        .dbg_state_o(dbg_state_o), .dbg_ptr_o(dbg_ptr_o)
    );

    // Clock / reset
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*WIDTH +: WIDTH] = dat[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; clr = 1'b0; valid = '0; pop = 1'b0; pop_id = '0; wready = 1'b0;
        repeat (cycles) tick();
        rst = 1'b0;
        m_ptr = 0; m_hold = -1;
        ids_q.delete();
    endtask

    function automatic int count_id(input int id);
        int n;
        n = 0;
        foreach (ids_q[k]) if (ids_q[k] == id) n++;
        return n;
    endfunction

    // Grant the model expects this cycle for the given eligible set.
    function automatic int model_grant(input logic [NUM_REQ-1:0] elig);
        if (m_hold >= 0) return m_hold;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (elig[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; pop = 1'b0; wready = 1'b1; valid = '1;
        for (int i = 0; i < NUM_REQ; i++) dat[i] = WIDTH'(16'h5A00 + i);
        for (int c = 0; c < 2; c++) begin
            #3;
            total++;
            if (fifo_wvalid_o !== 1'b0 || req_ready_o !== '0 || fifo_wdata_o !== '0 ||
                fifo_wid_o !== '0 || occ_o !== '0) begin
                bad++;
                $display("FAIL reset_outputs c%0d: wvalid=%b ready=%b wdata=%h wid=%0d occ=%h, required all zero",
                         c, fifo_wvalid_o, req_ready_o, fifo_wdata_o, fifo_wid_o, occ_o);
            end
            tick();
        end
        total++;
        if (dbg_state_o !== 1'b0 || dbg_ptr_o !== '0) begin
            bad++;
            $display("FAIL reset_state: state=%b ptr=%0d, required 0 0", dbg_state_o, dbg_ptr_o);
        end
        rst = 1'b0;
        #3;
        total++;
        if (fifo_wvalid_o !== 1'b1 || fifo_wid_o !== 2'd0 || req_ready_o !== 4'b0001 ||
            fifo_wdata_o !== 16'h5A00) begin
            bad++;
            $display("FAIL reset_first_grant: wvalid=%b wid=%0d ready=%b wdata=%h, required 1 0 0001 5a00",
                     fifo_wvalid_o, fifo_wid_o, req_ready_o, fifo_wdata_o);
        end
        tick();
    endtask

    task automatic test_fairness();
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset(1);
        for (int i = 0; i < NUM_REQ; i++) dat[i] = WIDTH'(16'hA000 + 16'h0101 * i);
        valid = '1; wready = 1'b1;
        for (int s = 0; s < 5; s++) begin
            #3;
            total++;
            if (fifo_wvalid_o !== 1'b1 || fifo_wid_o !== IDW'(order[s]) ||
                fifo_wdata_o !== dat[order[s]] || req_ready_o !== (NUM_REQ'(1) << order[s])) begin
                bad++;
                $display("FAIL fairness s%0d: wvalid=%b wid=%0d wdata=%h ready=%b, required 1 %0d %h %b",
                         s, fifo_wvalid_o, fifo_wid_o, fifo_wdata_o, req_ready_o,
                         order[s], dat[order[s]], NUM_REQ'(1) << order[s]);
            end
            tick();
        end
    endtask

    task automatic test_hold();
        do_reset(1);
        dat[0] = 16'h0C0C; dat[2] = 16'h2C2C;
        valid = 4'b0100; wready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) valid[0] = 1'b1;
            #3;
            total++;
            if (fifo_wvalid_o !== 1'b1 || fifo_wid_o !== 2'd2 || fifo_wdata_o !== 16'h2C2C ||
                req_ready_o !== '0) begin
                bad++;
                $display("FAIL hold_locked c%0d: wvalid=%b wid=%0d wdata=%h ready=%b, required 1 2 2c2c 0000",
                         c, fifo_wvalid_o, fifo_wid_o, fifo_wdata_o, req_ready_o);
            end
            tick();
        end
        total++;
        if (dbg_state_o !== 1'b1) begin
            bad++;
            $display("FAIL hold_state: state=%b, required 1", dbg_state_o);
        end
        wready = 1'b1;
        #3;
        total++;
        if (fifo_wid_o !== 2'd2 || req_ready_o !== 4'b0100) begin
            bad++;
            $display("FAIL hold_accept: wid=%0d ready=%b, required 2 0100", fifo_wid_o, req_ready_o);
        end
        tick();
        valid[2] = 1'b0;
        #3;
        total++;
        if (fifo_wvalid_o !== 1'b1 || fifo_wid_o !== 2'd0 || req_ready_o !== 4'b0001 ||
            fifo_wdata_o !== 16'h0C0C) begin
            bad++;
            $display("FAIL hold_next_grant: wvalid=%b wid=%0d ready=%b wdata=%h, required 1 0 0001 0c0c",
                     fifo_wvalid_o, fifo_wid_o, req_ready_o, fifo_wdata_o);
        end
        tick();
    endtask

    task automatic test_clr_hold();
        do_reset(1);
        dat[1] = 16'h1111; dat[3] = 16'h3333;
        valid = 4'b0010; wready = 1'b1;      // accept req1, pointer moves to 2
        tick();
        valid = 4'b1000; wready = 1'b0;      // req3 stalls into HOLD
        tick();
        #3;
        total++;
        if (dbg_state_o !== 1'b1 || fifo_wid_o !== 2'd3) begin
            bad++;
            $display("FAIL clr_pre_hold: state=%b wid=%0d, required 1 3", dbg_state_o, fifo_wid_o);
        end
        #2;
        @(posedge clk); #1;
        clr = 1'b1;
        #3;
        total++;
        if (fifo_wvalid_o !== 1'b0 || req_ready_o !== '0 || fifo_wdata_o !== '0) begin
            bad++;
            $display("FAIL clr_outputs: wvalid=%b ready=%b wdata=%h, required 0 0000 0000",
                     fifo_wvalid_o, req_ready_o, fifo_wdata_o);
        end
        tick();
        clr = 1'b0; valid = 4'b1010;
        #3;
        total++;
        if (dbg_state_o !== 1'b0 || dbg_ptr_o !== '0 || occ_o !== '0) begin
            bad++;
            $display("FAIL clr_state: state=%b ptr=%0d occ=%h, required 0 0 0",
                     dbg_state_o, dbg_ptr_o, occ_o);
        end
        total++;
        if (fifo_wvalid_o !== 1'b1 || fifo_wid_o !== 2'd1) begin
            bad++;
            $display("FAIL clr_regrant: wvalid=%b wid=%0d, required 1 1", fifo_wvalid_o, fifo_wid_o);
        end
        tick();
    endtask

`ifdef PRIM_FIFO_ARB_QUOTA_EN
    task automatic test_quota();
        do_reset(1);
        dat[1] = 16'hBEEF; valid = 4'b0010; wready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #3;
            total++;
            if (fifo_wvalid_o !== 1'b1 || fifo_wid_o !== 2'd1) begin
                bad++;
                $display("FAIL quota_accept c%0d: wvalid=%b wid=%0d, required 1 1", c, fifo_wvalid_o, fifo_wid_o);
            end
            tick();
        end
        #3;
        total++;
        if (fifo_wvalid_o !== 1'b0 || occ_o[1*CW +: CW] !== 3'd2) begin
            bad++;
            $display("FAIL quota_block: wvalid=%b occ1=%0d, required 0 2", fifo_wvalid_o, occ_o[1*CW +: CW]);
        end
        tick();
        pop = 1'b1; pop_id = 2'd1;
        #3;
        total++;
        if (fifo_wvalid_o !== 1'b0) begin
            bad++;
            $display("FAIL quota_pop_lag: wvalid=%b, required 0", fifo_wvalid_o);
        end
        tick();
        pop = 1'b0;
        #3;
        total++;
        if (fifo_wvalid_o !== 1'b1 || fifo_wid_o !== 2'd1 || occ_o[1*CW +: CW] !== 3'd1) begin
            bad++;
            $display("FAIL quota_resume: wvalid=%b wid=%0d occ1=%0d, required 1 1 1",
                     fifo_wvalid_o, fifo_wid_o, occ_o[1*CW +: CW]);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset(1);
        wready = 1'b1;
        valid = 4'b1000; tick();             // occ3 = 1
        valid = 4'b0010; tick();             // occ1 = 1
        pop = 1'b1; pop_id = 2'd1;           // push 1 and pop 1 together
        tick();
        pop = 1'b0; valid = '0;
        #3;
        total++;
        if (occ_o !== {3'd1, 3'd0, 3'd1, 3'd0}) begin
            bad++;
            $display("FAIL simul_same_id: occ=%h, required %h", occ_o, {3'd1, 3'd0, 3'd1, 3'd0});
        end
        tick();
        valid = 4'b0001; pop = 1'b1; pop_id = 2'd3;
        tick();
        pop = 1'b0; valid = '0;
        #3;
        total++;
        if (occ_o !== {3'd0, 3'd0, 3'd1, 3'd1}) begin
            bad++;
            $display("FAIL simul_diff_id: occ=%h, required %h", occ_o, {3'd0, 3'd0, 3'd1, 3'd1});
        end
        tick();
    endtask
`endif

    task automatic test_random();
        logic [NUM_REQ-1:0]    elig;
        logic [NUM_REQ*CW-1:0] exp_occ;
        logic [NUM_REQ-1:0]    exp_ready;
        logic [SBW-1:0]        got;
        int g;
        do_reset(1);
        exp_q.delete();
        for (int i = 0; i < NUM_REQ; i++) begin
            valid[i] = 1'($urandom_range(1));
            dat[i]   = WIDTH'($urandom);
        end
        for (int c = 0; c < 400; c++) begin
            clr    = ($urandom_range(39) == 0);
            pop    = !clr && (ids_q.size() > 0) && ($urandom_range(1) == 1);
            pop_id = pop ? IDW'(ids_q[0]) : '0;
            wready = ($urandom_range(3) != 0) && (ids_q.size() < FIFO_DEPTH);
            #3;
            elig    = valid;
            exp_occ = '0;
`ifdef PRIM_FIFO_ARB_QUOTA_EN
            for (int i = 0; i < NUM_REQ; i++) begin
                exp_occ[i*CW +: CW] = CW'(count_id(i));
                if (count_id(i) >= QUOTA) elig[i] = 1'b0;
            end
`endif
            g = clr ? -1 : model_grant(elig);
            exp_ready = (g >= 0 && wready) ? (NUM_REQ'(1) << g) : '0;
            total++;
            if (fifo_wvalid_o !== (g >= 0) || req_ready_o !== exp_ready) begin
                bad++;
                $display("FAIL rand_handshake c%0d: wvalid=%b ready=%b, required %b %b",
                         c, fifo_wvalid_o, req_ready_o, g >= 0, exp_ready);
            end
            if (g >= 0) begin
                total++;
                if (fifo_wid_o !== IDW'(g) || fifo_wdata_o !== dat[g]) begin
                    bad++;
                    $display("FAIL rand_grant c%0d: wid=%0d wdata=%h, required %0d %h",
                             c, fifo_wid_o, fifo_wdata_o, g, dat[g]);
                end
            end
            total++;
            if (occ_o !== exp_occ) begin
                bad++;
                $display("FAIL rand_occ c%0d: occ=%h, required %h", c, occ_o, exp_occ);
            end
            if (g >= 0 && wready) exp_q.push_back({IDW'(g), dat[g]});
            if (fifo_wvalid_o === 1'b1 && wready) begin
                got = {fifo_wid_o, fifo_wdata_o};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rand_sb_extra c%0d: write %h, required none", c, got);
                end else if (got !== exp_q[0]) begin
                    bad++;
                    $display("FAIL rand_sb c%0d: write %h, required %h", c, got, exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            @(posedge clk);
            #1;
            if (clr) begin
                m_ptr = 0; m_hold = -1;
                ids_q.delete();
            end else begin
                if (pop) void'(ids_q.pop_front());
                if (g >= 0) begin
                    if (wready) begin
                        m_ptr  = (g + 1) % NUM_REQ;
                        m_hold = -1;
                        ids_q.push_back(g);
                        valid[g] = 1'($urandom_range(1));
                        dat[g]   = WIDTH'($urandom);
                    end else begin
                        m_hold = g;
                    end
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!valid[i] && $urandom_range(2) == 0) begin
                    valid[i] = 1'b1;
                    dat[i]   = WIDTH'($urandom);
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rand_sb_left: %0d expected writes unseen, required 0", exp_q.size());
        end
        clr = 1'b0; pop = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) dat[i] = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_fairness();
        test_hold();
        test_clr_hold();
`ifdef PRIM_FIFO_ARB_QUOTA_EN
        test_quota();
        test_simultaneous();
`endif
        test_random();
        do_reset(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
